// File: rtl/change_sequencer.sv
// change_sequencer: pays out change in 5-cent units from a dime/nickel hopper,
// highest coin first, waiting for a hopper ack after every ejection.
// Ports: clk, reset (sync, active-high); req_valid/req_amount/req_ready request
// handshake; eject_dime/eject_nickel one-cycle hopper commands; hopper_ack;
// restock_dime/restock_nickel; done/short completion; fault/fault_clr timeout;
// dime_count/nickel_count inventory; remaining amount still owed.
// Option: define CHANGE_SEQUENCER_QUARTER_HOPPER_EN to add a quarter hopper
// (eject_quarter, restock_quarter, quarter_count, parameter QUARTER_INIT).
module change_sequencer #(
    parameter int DIME_INIT   = 8,
    parameter int NICKEL_INIT = 8,
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
    parameter int QUARTER_INIT = 4,
`endif
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [4:0] req_amount,
    output logic       req_ready,
    input  logic       hopper_ack,
    output logic       eject_dime,
    output logic       eject_nickel,
    input  logic       restock_dime,
    input  logic       restock_nickel,
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
    output logic       eject_quarter,
    input  logic       restock_quarter,
    output logic [3:0] quarter_count,
`endif
    output logic       done,
    output logic       short,
    output logic       fault,
    input  logic       fault_clr,
    output logic [3:0] dime_count,
    output logic [3:0] nickel_count,
    output logic [4:0] remaining
);

    typedef enum logic [2:0] {
        IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT
    } state_t;

    typedef enum logic [1:0] {
        COIN_NICKEL, COIN_DIME, COIN_QUARTER
    } coin_t;

    localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    coin_t      coin;
    logic [7:0] timer;

    // A coin leaves inventory on the cycle the FSM exits EJECT.
    logic dime_dec, nickel_dec;
    assign dime_dec   = (state == EJECT) && (coin == COIN_DIME);
    assign nickel_dec = (state == EJECT) && (coin == COIN_NICKEL);

    assign req_ready    = (state == IDLE);
    assign eject_dime   = dime_dec;
    assign eject_nickel = nickel_dec;
    assign done         = (state == DONE);
    assign short        = (state == DONE) && (remaining != 5'd0);
    assign fault        = (state == FAULT);

    // Restock and decrement together cancel; restock saturates at 15.
    function automatic logic [3:0] upd(input logic [3:0] c,
                                       input logic inc,
                                       input logic dec);
        if (dec && !inc)
            return c - 4'd1;
        else if (inc && !dec && c != 4'd15)
            return c + 4'd1;
        else
            return c;
    endfunction

`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
    logic quarter_dec;
    assign quarter_dec   = (state == EJECT) && (coin == COIN_QUARTER);
    assign eject_quarter = quarter_dec;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            coin         <= COIN_NICKEL;
            timer        <= 8'd0;
            remaining    <= 5'd0;
            dime_count   <= 4'(DIME_INIT);
            nickel_count <= 4'(NICKEL_INIT);
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
            quarter_count <= 4'(QUARTER_INIT);
`endif
        end else begin
            dime_count   <= upd(dime_count, restock_dime, dime_dec);
            nickel_count <= upd(nickel_count, restock_nickel, nickel_dec);
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
            quarter_count <= upd(quarter_count, restock_quarter, quarter_dec);
`endif
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amount;
                        state     <= (req_amount == 5'd0) ? DONE : SELECT;
                    end
                end
                SELECT: begin
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
                    if (remaining >= 5'd5 && quarter_count != 4'd0) begin
                        coin  <= COIN_QUARTER;
                        state <= EJECT;
                    end else
`endif
                    if (remaining >= 5'd2 && dime_count != 4'd0) begin
                        coin  <= COIN_DIME;
                        state <= EJECT;
                    end else if (remaining >= 5'd1 && nickel_count != 4'd0) begin
                        coin  <= COIN_NICKEL;
                        state <= EJECT;
                    end else begin
                        state <= DONE;
                    end
                end
                EJECT: begin
                    unique case (coin)
                        COIN_DIME:    remaining <= remaining - 5'd2;
                        COIN_QUARTER: remaining <= remaining - 5'd5;
                        default:      remaining <= remaining - 5'd1;
                    endcase
                    timer <= 8'd0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Faults after exactly ACK_TIMEOUT cycles without ack.
                    if (hopper_ack)
                        state <= SELECT;
                    else if (timer == TMAX)
                        state <= FAULT;
                    else
                        timer <= timer + 8'd1;
                end
                DONE: begin
                    remaining <= 5'd0;
                    state     <= IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        remaining <= 5'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_sequencer.sv
// tb_change_sequencer: directed self-checking bench for change_sequencer.
// u0 uses default parameters; u1 uses DIME_INIT=0, NICKEL_INIT=2.
module tb_change_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] req_amount = 5'd0;
    logic       hopper_ack = 1'b0;
    logic       restock_dime = 1'b0;
    logic       restock_nickel = 1'b0;
    logic       fault_clr = 1'b0;
    logic       req_ready, eject_dime, eject_nickel, done, short, fault;
    logic [3:0] dime_count, nickel_count;
    logic [4:0] remaining;

    logic       req_valid1 = 1'b0;
    logic [4:0] req_amount1 = 5'd0;
    logic       hopper_ack1 = 1'b0;
    logic       zero = 1'b0;
    logic       req_ready1, eject_dime1, eject_nickel1, done1, short1, fault1;
    logic [3:0] dime_count1, nickel_count1;
    logic [4:0] remaining1;

`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
    logic       restock_quarter = 1'b0;
    logic       eject_quarter, eject_quarter1;
    logic [3:0] quarter_count, quarter_count1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_sequencer u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .hopper_ack(hopper_ack),
        .eject_dime(eject_dime), .eject_nickel(eject_nickel),
        .restock_dime(restock_dime), .restock_nickel(restock_nickel),
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
        .eject_quarter(eject_quarter), .restock_quarter(restock_quarter),
        .quarter_count(quarter_count),
`endif
        .done(done), .short(short), .fault(fault), .fault_clr(fault_clr),
        .dime_count(dime_count), .nickel_count(nickel_count),
        .remaining(remaining)
    );

    change_sequencer #(.DIME_INIT(0), .NICKEL_INIT(2)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_amount(req_amount1), .req_ready(req_ready1),
        .hopper_ack(hopper_ack1),
        .eject_dime(eject_dime1), .eject_nickel(eject_nickel1),
        .restock_dime(zero), .restock_nickel(zero),
`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
        .eject_quarter(eject_quarter1), .restock_quarter(zero),
        .quarter_count(quarter_count1),
`endif
        .done(done1), .short(short1), .fault(fault1), .fault_clr(zero),
        .dime_count(dime_count1), .nickel_count(nickel_count1),
        .remaining(remaining1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_eject_d", 32'(eject_dime), 0);
        chk("rst_eject_n", 32'(eject_nickel), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_short", 32'(short), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_dime", 32'(dime_count), 8);
        chk("rst_nickel", 32'(nickel_count), 8);
        chk("rst_rem", 32'(remaining), 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(req_ready), 1);

        // u1: request 4 with no dimes, only two nickels
        req_valid1 = 1'b1; req_amount1 = 5'd4;
        tick();
        req_valid1 = 1'b0;
        tick();
        chk("u1_ej1_n", 32'(eject_nickel1), 1);
        chk("u1_ej1_d", 32'(eject_dime1), 0);
        tick();
        chk("u1_rem3", 32'(remaining1), 3);
        hopper_ack1 = 1'b1;
        tick();
        hopper_ack1 = 1'b0;
        tick();
        chk("u1_ej2_n", 32'(eject_nickel1), 1);
        tick();
        hopper_ack1 = 1'b1;
        tick();
        hopper_ack1 = 1'b0;
        tick();
        chk("u1_done", 32'(done1), 1);
        chk("u1_short", 32'(short1), 1);
        chk("u1_rem", 32'(remaining1), 2);
        chk("u1_nickel", 32'(nickel_count1), 0);
        tick();
        chk("u1_idle_rem", 32'(remaining1), 0);
        chk("u1_idle_rdy", 32'(req_ready1), 1);

        // u0: request 3 -> dime then nickel, exact cycle timing
        req_valid = 1'b1; req_amount = 5'd3;
        tick();
        req_valid = 1'b0;
        chk("r3_sel_rdy", 32'(req_ready), 0);
        chk("r3_sel_rem", 32'(remaining), 3);
        tick();
        chk("r3_ej_d", 32'(eject_dime), 1);
        chk("r3_ej_n0", 32'(eject_nickel), 0);
        tick();
        chk("r3_wait_d", 32'(eject_dime), 0);
        chk("r3_dime7", 32'(dime_count), 7);
        chk("r3_rem1", 32'(remaining), 1);
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        chk("r3_ej_n", 32'(eject_nickel), 1);
        chk("r3_ej_d0", 32'(eject_dime), 0);
        tick();
        chk("r3_nickel7", 32'(nickel_count), 7);
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        chk("r3_done", 32'(done), 1);
        chk("r3_short", 32'(short), 0);
        tick();
        chk("r3_done_off", 32'(done), 0);
        chk("r3_ready", 32'(req_ready), 1);

        // Request 0 -> done the next cycle, no eject
        req_valid = 1'b1; req_amount = 5'd0;
        tick();
        req_valid = 1'b0;
        chk("r0_done", 32'(done), 1);
        chk("r0_short", 32'(short), 0);
        chk("r0_ej", 32'({eject_dime, eject_nickel}), 0);
        tick();
        chk("r0_dime", 32'(dime_count), 7);
        chk("r0_nickel", 32'(nickel_count), 7);

        // Request 2 with no ack -> fault after ACK_TIMEOUT cycles
        do_reset();
        req_valid = 1'b1; req_amount = 5'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_nofault", 32'(fault), 0);
        tick();
        chk("to_fault", 32'(fault), 1);
        chk("to_rdy", 32'(req_ready), 0);
        req_valid = 1'b1;
        hopper_ack = 1'b1;
        tick();
        req_valid = 1'b0;
        hopper_ack = 1'b0;
        chk("to_held", 32'(fault), 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", 32'(fault), 0);
        chk("clr_rdy", 32'(req_ready), 1);
        chk("clr_done", 32'(done), 0);
        chk("clr_dime", 32'(dime_count), 7);
        chk("clr_rem", 32'(remaining), 0);

        // Restock saturation, and restock cancelling a decrement
        do_reset();
        restock_dime = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        restock_dime = 1'b0;
        chk("rs_sat", 32'(dime_count), 15);
        req_valid = 1'b1; req_amount = 5'd2;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rs_ej_d", 32'(eject_dime), 1);
        restock_dime = 1'b1;
        tick();
        restock_dime = 1'b0;
        chk("rs_cancel", 32'(dime_count), 15);
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        chk("rs_done", 32'(done), 1);
        chk("rs_short", 32'(short), 0);
        tick();

        // Reset mid-ejection abandons the request
        req_valid = 1'b1; req_amount = 5'd1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mr_ej_n", 32'(eject_nickel), 1);
        reset = 1'b1;
        restock_nickel = 1'b1;
        tick();
        chk("mr_ej_off", 32'(eject_nickel), 0);
        chk("mr_nickel", 32'(nickel_count), 8);
        chk("mr_rem", 32'(remaining), 0);
        reset = 1'b0;
        restock_nickel = 1'b0;
        tick();
        chk("mr_done", 32'(done), 0);
        chk("mr_rdy", 32'(req_ready), 1);

`ifdef CHANGE_SEQUENCER_QUARTER_HOPPER_EN
        // Request 7 -> quarter then dime
        req_valid = 1'b1; req_amount = 5'd7;
        tick();
        req_valid = 1'b0;
        tick();
        chk("q_ej_q", 32'(eject_quarter), 1);
        tick();
        chk("q_count", 32'(quarter_count), 3);
        chk("q_rem", 32'(remaining), 2);
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        chk("q_ej_d", 32'(eject_dime), 1);
        tick();
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        chk("q_done", 32'(done), 1);
        chk("q_short", 32'(short), 0);
        chk("q_final", 32'(quarter_count), 3);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
